rti_return_handler: RTL and testbench
=====================================

Name: rti_return_handler

Overview:
Return-from-interrupt sequencer, the unwinding counterpart of the interrupt entry handler. On an RTI detected in decode, it:
- stalls fetch;
- injects a bubble and three POP instructions into the decode path (flags, PC high, PC low);
- collects the popped words as they return from the memory stage;
- redirects fetch to the restored PC and restores the flags in a single cycle.

It sits beside decode, with its instruction output muxed ahead of the fetched instruction.

Parameters:
PC_WIDTH, 32, width of restored PC; built from two 16-bit stack words.
FLAG_WIDTH, 3, number of flag bits restored from the low bits of the flags word.
WAIT_LIMIT, 15, cycles allowed in WAIT_MEM before timeout; used only with RTI_TIMEOUT_EN.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
rtiDetected  in  1  decode has an RTI this cycle; single-cycle pulse.
memPopValid  in  1  memory stage is returning a popped stack word this cycle.
memPopData  in  16  popped word.
rtiBusy  out  1  sequence in progress.
stallFetch  out  1  hold PC and fetch register.
rtiInstructionValid  out  1  decode selects rtiInstruction instead of the fetched instruction.
rtiInstruction  out  16  injected instruction.
returnRaisedToFetch  out  1  one-cycle redirect strobe.
returnPc  out  PC_WIDTH  redirect target; valid with the strobe.
flagsRestoreValid  out  1  one-cycle flag restore strobe.
restoredFlags  out  FLAG_WIDTH  flags to load; valid with the strobe.
rtiError  out  1  one-cycle timeout strobe; tied 0 without RTI_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, active-high):
  - all outputs 0, state IDLE, pop counter 0, capture registers 0.
  - rst mid-sequence aborts at the next edge: no redirect and no flag strobe are issued.
- All outputs are registered.
- States: IDLE, BUBBLE, POP_FLAGS, POP_PC_HI, POP_PC_LO, WAIT_MEM, REDIRECT.
- Transitions:
  - IDLE: rtiDetected → BUBBLE.
  - BUBBLE, POP_FLAGS, POP_PC_HI advance unconditionally to the next state.
  - POP_PC_LO → WAIT_MEM.
  - WAIT_MEM → REDIRECT once 3 words are captured. A capture in the same cycle counts.
  - REDIRECT → IDLE.
- rtiBusy and stallFetch are 1 in every non-IDLE state.
- rtiDetected is ignored while busy.
- Injection: rtiInstructionValid = 1 in BUBBLE, POP_FLAGS, POP_PC_HI and POP_PC_LO only. rtiInstruction values:
  - BUBBLE: BUBBLE_INSTR = 16'h07F8.
  - POP_FLAGS: POP_FLAGS_INSTR = 16'hF500.
  - POP_PC_HI: POP_PC_HI_INSTR = 16'hF580.
  - POP_PC_LO: POP_PC_LO_INSTR = 16'hF5C0.
  - All other states: BUBBLE_INSTR, with valid = 0.
- Capture:
  - memPopValid is accepted only from POP_PC_HI through WAIT_MEM, i.e. after the first POP has been injected. It is ignored elsewhere.
  - Counter 0→1→2→3 with fixed mapping:
    - word 0 → flags (low FLAG_WIDTH bits);
    - word 1 → returnPc[31:16];
    - word 2 → returnPc[15:0].
  - A 4th return is ignored.
- REDIRECT (exactly one cycle):
  - returnRaisedToFetch = 1, flagsRestoreValid = 1, returnPc and restoredFlags valid.
  - Next cycle: strobes 0, rtiBusy 0.
  - returnPc and restoredFlags hold their last values until the next capture.
- Minimum latency with pops returning 3 cycles after injection:
  - rtiDetected at cycle 0;
  - injections at cycles 1–4;
  - returns at cycles 5, 6, 7;
  - REDIRECT at cycle 8.
- rtiDetected during REDIRECT is ignored. The pipeline has been flushed, so decode cannot legitimately present one.

Optional Feature:
RTI_TIMEOUT_EN.
- Defined:
  - cycle counter runs in WAIT_MEM and clears on entry;
  - if the counter reaches WAIT_LIMIT with fewer than 3 words captured, pulse rtiError for 1 cycle and return to IDLE;
  - no redirect or flag strobe; capture registers are not updated further.
- Undefined:
  - WAIT_MEM waits indefinitely;
  - rtiError is constant 0.

Decomposition:
- Shared package interrupt_pkg holds:
  - state enum rti_state_t;
  - BUBBLE_INSTR, POP_FLAGS_INSTR, POP_PC_HI_INSTR, POP_PC_LO_INSTR;
  - the push-order constants shared with the interrupt entry handler, so push and pop ordering stay consistent.
- One natural sub-module, rti_pop_collector: pop counter plus the capture registers for flags and both PC halves. It has clear and accept inputs and a done output. The FSM stays in the top level.

Test Plan:
- Nominal: rtiDetected@0; returns 16'h0005, 16'h0000, 16'h0123 at cycles 5/6/7 → injected sequence 07F8, F500, F580, F5C0 at cycles 1–4; REDIRECT@8 with returnPc = 32'h0000_0123, restoredFlags = 3'b101; rtiBusy 0 @9.
- Delayed memory: returns at cycles 10/14/20 → stallFetch held through cycle 20; single redirect strobe @21; no rtiInstructionValid after cycle 4.
- Spurious inputs: memPopValid at cycle 2 (POP_FLAGS), then a 4th return after REDIRECT, plus rtiDetected at cycle 3 → all ignored; captured values equal the three in-window returns; exactly one sequence runs.
- Reset mid-sequence: rst asserted at cycle 6 after one capture → next edge all outputs 0; no returnRaisedToFetch; a fresh rtiDetected then completes normally with new data.
- Timeout (RTI_TIMEOUT_EN, WAIT_LIMIT = 15): only 2 returns → rtiError pulse exactly 15 cycles after WAIT_MEM entry; no redirect; IDLE next cycle. Without the macro: same stimulus → busy indefinitely, rtiError stays 0.
- Back-to-back: second rtiDetected on the cycle after REDIRECT → BUBBLE on the next cycle; second returnPc 32'h0001_0040 overrides the first.

Source files
------------

// File: rtl/interrupt_pkg.sv
// Shared definitions for the interrupt entry/return handlers: RTI sequencer
// states, injected instruction encodings and stack word ordering.
package interrupt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUBBLE,
        POP_FLAGS,
        POP_PC_HI,
        POP_PC_LO,
        WAIT_MEM,
        REDIRECT
    } rti_state_t;

    localparam logic [15:0] BUBBLE_INSTR    = 16'h07F8;
    localparam logic [15:0] POP_FLAGS_INSTR = 16'hF500;
    localparam logic [15:0] POP_PC_HI_INSTR = 16'hF580;
    localparam logic [15:0] POP_PC_LO_INSTR = 16'hF5C0;

    // Entry handler pushes PC low first and flags last; pops see the reverse.
    localparam logic [1:0] STACK_WORDS    = 2'd3;
    localparam logic [1:0] PUSH_IDX_PC_LO = 2'd0;
    localparam logic [1:0] PUSH_IDX_PC_HI = 2'd1;
    localparam logic [1:0] PUSH_IDX_FLAGS = 2'd2;
    localparam logic [1:0] POP_IDX_FLAGS  = STACK_WORDS - 2'd1 - PUSH_IDX_FLAGS;
    localparam logic [1:0] POP_IDX_PC_HI  = STACK_WORDS - 2'd1 - PUSH_IDX_PC_HI;
    localparam logic [1:0] POP_IDX_PC_LO  = STACK_WORDS - 2'd1 - PUSH_IDX_PC_LO;

    function automatic logic [15:0] injectFor(rti_state_t s);
        case (s)
            POP_FLAGS: return POP_FLAGS_INSTR;
            POP_PC_HI: return POP_PC_HI_INSTR;
            POP_PC_LO: return POP_PC_LO_INSTR;
            default:   return BUBBLE_INSTR;
        endcase
    endfunction

    function automatic logic isInjectState(rti_state_t s);
        return s inside {BUBBLE, POP_FLAGS, POP_PC_HI, POP_PC_LO};
    endfunction

endpackage

// File: rtl/rti_return_handler_if.sv
// Decode/memory-side signal bundle of the RTI return sequencer.
interface rti_return_handler_if #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned FLAG_WIDTH = 3
);
    logic                  rtiDetected;
    logic                  memPopValid;
    logic [15:0]           memPopData;
    logic                  rtiBusy;
    logic                  stallFetch;
    logic                  rtiInstructionValid;
    logic [15:0]           rtiInstruction;
    logic                  returnRaisedToFetch;
    logic [PC_WIDTH-1:0]   returnPc;
    logic                  flagsRestoreValid;
    logic [FLAG_WIDTH-1:0] restoredFlags;
    logic                  rtiError;

    modport master (
        input  rtiDetected, memPopValid, memPopData,
        output rtiBusy, stallFetch, rtiInstructionValid, rtiInstruction,
               returnRaisedToFetch, returnPc, flagsRestoreValid, restoredFlags, rtiError
    );

    modport slave (
        output rtiDetected, memPopValid, memPopData,
        input  rtiBusy, stallFetch, rtiInstructionValid, rtiInstruction,
               returnRaisedToFetch, returnPc, flagsRestoreValid, restoredFlags, rtiError
    );
endinterface

// File: rtl/rti_return_handler_collector.sv
// Pop counter and capture registers for the three stack words returned
// during an RTI sequence (flags, PC high, PC low).
module rti_pop_collector
    import interrupt_pkg::*;
#(
    parameter int unsigned FLAG_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [15:0]           popData,
    output logic [FLAG_WIDTH-1:0] flags,
    output logic [15:0]           pcHi,
    output logic [15:0]           pcLo,
    output logic                  done
);
    logic [1:0] popCount;
    logic       take;

    assign take = accept && (popCount != STACK_WORDS);
    // A capture arriving this cycle already completes the set.
    assign done = (popCount == STACK_WORDS) || (take && popCount == STACK_WORDS - 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            popCount <= '0;
            flags    <= '0;
            pcHi     <= '0;
            pcLo     <= '0;
        end else if (clear) begin
            popCount <= '0;
        end else if (take) begin
            case (popCount)
                POP_IDX_FLAGS: flags <= popData[FLAG_WIDTH-1:0];
                POP_IDX_PC_HI: pcHi  <= popData;
                POP_IDX_PC_LO: pcLo  <= popData;
                default: ;
            endcase
            popCount <= popCount + 2'd1;
        end
    end
endmodule

// File: rtl/rti_return_handler.sv
// Return-from-interrupt sequencer: injects bubble + three POPs, collects the
// popped words and redirects fetch. Optional WAIT_MEM timeout: RTI_TIMEOUT_EN.
module rti_return_handler
    import interrupt_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned FLAG_WIDTH = 3,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input logic               clk,
    input logic               rst,
    rti_return_handler_if.master bus
);
    rti_state_t            state, nextState;
    logic                  busyR, instrValidR, redirectR;
    logic [15:0]           instrR;
    logic                  accept, clear, done, timeoutHit;
    logic [FLAG_WIDTH-1:0] capFlags;
    logic [15:0]           capPcHi, capPcLo;

    assign accept = bus.memPopValid && (state inside {POP_PC_HI, POP_PC_LO, WAIT_MEM});
    assign clear  = (state == IDLE);

    rti_pop_collector #(.FLAG_WIDTH(FLAG_WIDTH)) collector (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .accept  (accept),
        .popData (bus.memPopData),
        .flags   (capFlags),
        .pcHi    (capPcHi),
        .pcLo    (capPcLo),
        .done    (done)
    );

`ifdef RTI_TIMEOUT_EN
    localparam int unsigned WAIT_CNT_W = $clog2(WAIT_LIMIT + 1);
    logic [WAIT_CNT_W-1:0] waitCnt;
    logic                  errorR;

    assign timeoutHit = (state == WAIT_MEM) && !done
                        && (waitCnt == WAIT_CNT_W'(WAIT_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt <= '0;
            errorR  <= 1'b0;
        end else begin
            waitCnt <= (state == WAIT_MEM) ? waitCnt + 1'b1 : '0;
            errorR  <= timeoutHit;
        end
    end

    assign bus.rtiError = errorR;
`else
    assign timeoutHit   = 1'b0;
    assign bus.rtiError = 1'b0;
`endif

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (bus.rtiDetected) nextState = BUBBLE;
            BUBBLE:    nextState = POP_FLAGS;
            POP_FLAGS: nextState = POP_PC_HI;
            POP_PC_HI: nextState = POP_PC_LO;
            POP_PC_LO: nextState = WAIT_MEM;
            WAIT_MEM: begin
                if (done)            nextState = REDIRECT;
                else if (timeoutHit) nextState = IDLE;
            end
            REDIRECT:  nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busyR       <= 1'b0;
            instrValidR <= 1'b0;
            instrR      <= '0;
            redirectR   <= 1'b0;
        end else begin
            state       <= nextState;
            busyR       <= (nextState != IDLE);
            instrValidR <= isInjectState(nextState);
            instrR      <= injectFor(nextState);
            redirectR   <= (nextState == REDIRECT);
        end
    end

    assign bus.rtiBusy             = busyR;
    assign bus.stallFetch          = busyR;
    assign bus.rtiInstructionValid = instrValidR;
    assign bus.rtiInstruction      = instrR;
    assign bus.returnRaisedToFetch = redirectR;
    assign bus.flagsRestoreValid   = redirectR;
    assign bus.returnPc            = PC_WIDTH'({capPcHi, capPcLo});
    assign bus.restoredFlags       = capFlags;
endmodule

// File: tb/tb_rti_return_handler.sv
// Self-checking bench for rti_return_handler: directed scenarios with literal
// expectations plus randomized traffic against a cycle-count reference model.
module tb_rti_return_handler;
    localparam int unsigned PC_WIDTH   = 32;
    localparam int unsigned FLAG_WIDTH = 3;
    localparam int unsigned WAIT_LIMIT = 15;
`ifdef RTI_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rti_return_handler_if #(.PC_WIDTH(PC_WIDTH), .FLAG_WIDTH(FLAG_WIDTH)) bus ();

    rti_return_handler #(
        .PC_WIDTH   (PC_WIDTH),
        .FLAG_WIDTH (FLAG_WIDTH),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks cycles since the RTI was accepted and the
    // popped stack words in order (word 0 flags, 1 PC high, 2 PC low).
    bit          mBusy, mRedir, mErr, mRstLast;
    int          mK, mCnt;
    logic [15:0] mWords [3];
    logic [15:0] instrTab [4] = '{16'h07F8, 16'hF500, 16'hF580, 16'hF5C0};

    always @(posedge clk) begin
        if (rst) begin
            mBusy = 0; mRedir = 0; mErr = 0; mRstLast = 1; mK = 0; mCnt = 0;
            mWords = '{default: '0};
        end else begin
            mRstLast = 0;
            // Pops count from the cycle after the first POP is injected.
            if (mBusy && !mRedir && mK >= 3 && bus.memPopValid && mCnt < 3) begin
                mWords[mCnt] = bus.memPopData;
                mCnt++;
            end
            mErr = 0;
            if (!mBusy) begin
                if (bus.rtiDetected) begin
                    mBusy = 1; mK = 1; mCnt = 0; mRedir = 0;
                end
            end else if (mRedir) begin
                mBusy = 0; mRedir = 0;
            end else if (mK >= 5 && mCnt == 3) begin
                mRedir = 1;
            end else if (TIMEOUT_ON && mK - 5 == int'(WAIT_LIMIT) - 1) begin
                mBusy = 0; mErr = 1;
            end else begin
                mK++;
            end
        end
    end

    logic        expIv;
    logic [15:0] expInstr;
    always @(negedge clk) begin
        if (armed) begin
            expIv    = mBusy && !mRedir && mK >= 1 && mK <= 4;
            expInstr = mRstLast ? 16'h0000 : (expIv ? instrTab[mK-1] : 16'h07F8);
            chk("ctrl", {58'd0, bus.rtiBusy, bus.stallFetch, bus.rtiInstructionValid,
                         bus.returnRaisedToFetch, bus.flagsRestoreValid, bus.rtiError},
                        {58'd0, mBusy, mBusy, expIv, mRedir, mRedir, mErr});
            chk("instr", {48'd0, bus.rtiInstruction}, {48'd0, expInstr});
            chk("returnPc", {32'd0, bus.returnPc}, {32'd0, mWords[1], mWords[2]});
            chk("restoredFlags", {61'd0, bus.restoredFlags}, {61'd0, mWords[0][2:0]});
        end
    end

    // Directed scenario tables, indexed by cycle within the scenario.
    bit          sRst [64], sDet [64], sPv [64];
    logic [15:0] sPd  [64];
    bit          recBusy [64], recIv [64], recRedir [64], recFv [64], recErr [64];
    logic [15:0] recInstr [64];
    logic [31:0] recPc [64];
    logic [2:0]  recFlags [64];

    task automatic drive(input bit r, input bit d, input bit pv, input logic [15:0] pd);
        rst = r;
        bus.rtiDetected = d;
        bus.memPopValid = pv;
        bus.memPopData  = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic pop(input int c, input logic [15:0] d);
        sPv[c] = 1'b1;
        sPd[c] = d;
    endtask

    task automatic runScen(input int len);
        for (int c = 0; c < len; c++) begin
            recBusy[c]  = bus.rtiBusy;
            recIv[c]    = bus.rtiInstructionValid;
            recInstr[c] = bus.rtiInstruction;
            recRedir[c] = bus.returnRaisedToFetch;
            recFv[c]    = bus.flagsRestoreValid;
            recErr[c]   = bus.rtiError;
            recPc[c]    = bus.returnPc;
            recFlags[c] = bus.restoredFlags;
            drive(sRst[c], sDet[c], sPv[c], sPd[c]);
        end
        for (int c = 0; c < 64; c++) begin
            sRst[c] = 0; sDet[c] = 0; sPv[c] = 0; sPd[c] = '0;
        end
    endtask

    function automatic int countOnes(input int lo, input int hi, input int which);
        int n = 0;
        for (int c = lo; c <= hi; c++)
            n += (which == 0) ? int'(recRedir[c]) : (which == 1) ? int'(recIv[c]) : int'(recErr[c]);
        return n;
    endfunction

    initial begin
        bus.rtiDetected = 0; bus.memPopValid = 0; bus.memPopData = '0;
        for (int c = 0; c < 64; c++) begin
            sRst[c] = 0; sDet[c] = 0; sPv[c] = 0; sPd[c] = '0;
        end
        drive(1, 0, 0, '0);
        armed = 1'b1;

        // Nominal sequence.
        sDet[0] = 1; pop(5, 16'h0005); pop(6, 16'h0000); pop(7, 16'h0123);
        runScen(12);
        chk("reset_busy", {63'd0, recBusy[0]}, 64'd0);
        chk("reset_instr", {48'd0, recInstr[0]}, 64'd0);
        chk("reset_pc", {32'd0, recPc[0]}, 64'd0);
        chk("nom_instr1", {48'd0, recInstr[1]}, 64'h07F8);
        chk("nom_instr2", {48'd0, recInstr[2]}, 64'hF500);
        chk("nom_instr3", {48'd0, recInstr[3]}, 64'hF580);
        chk("nom_instr4", {48'd0, recInstr[4]}, 64'hF5C0);
        chk("nom_ivcount", 64'(countOnes(0, 11, 1)), 64'd4);
        chk("nom_redir7", {63'd0, recRedir[7]}, 64'd0);
        chk("nom_redir8", {62'd0, recRedir[8], recFv[8]}, 64'd3);
        chk("nom_pc8", {32'd0, recPc[8]}, 64'h0000_0123);
        chk("nom_flags8", {61'd0, recFlags[8]}, 64'd5);
        chk("nom_busy9", {62'd0, recBusy[9], recRedir[9]}, 64'd0);

        // Delayed memory returns.
        drive(1, 0, 0, '0);
        sDet[0] = 1; pop(10, 16'h0002); pop(14, 16'hABCD); pop(20, 16'h1234);
        runScen(26);
        chk("dly_iv_after4", 64'(countOnes(5, 25, 1)), 64'd0);
`ifndef RTI_TIMEOUT_EN
        chk("dly_stall20", {62'd0, recBusy[20], recRedir[20]}, 64'd2);
        chk("dly_redir21", {63'd0, recRedir[21]}, 64'd1);
        chk("dly_redircount", 64'(countOnes(0, 25, 0)), 64'd1);
        chk("dly_pc21", {32'd0, recPc[21]}, 64'hABCD_1234);
        chk("dly_flags21", {61'd0, recFlags[21]}, 64'd2);
`endif

        // Spurious pops and detects.
        drive(1, 0, 0, '0);
        sDet[0] = 1; pop(2, 16'hFFFF); sDet[3] = 1;
        pop(5, 16'h0003); pop(6, 16'h1111); pop(7, 16'h2222); pop(8, 16'h9999); pop(9, 16'h8888);
        runScen(16);
        chk("spur_pc8", {32'd0, recPc[8]}, 64'h1111_2222);
        chk("spur_flags8", {61'd0, recFlags[8]}, 64'd3);
        chk("spur_pc_hold", {32'd0, recPc[14]}, 64'h1111_2222);
        chk("spur_redircount", 64'(countOnes(0, 15, 0)), 64'd1);
        chk("spur_ivcount", 64'(countOnes(0, 15, 1)), 64'd4);

        // Reset mid-sequence, then a fresh sequence.
        drive(1, 0, 0, '0);
        sDet[0] = 1; pop(5, 16'h0007); sRst[6] = 1;
        sDet[10] = 1; pop(15, 16'h0006); pop(16, 16'h00AB); pop(17, 16'h00CD);
        runScen(22);
        chk("rst_outputs7", {recBusy[7], recIv[7], recRedir[7], recFv[7], recErr[7],
                             recInstr[7], recPc[7], recFlags[7], 8'd0}, 64'd0);
        chk("rst_redir18", {63'd0, recRedir[18]}, 64'd1);
        chk("rst_pc18", {32'd0, recPc[18]}, 64'h00AB_00CD);
        chk("rst_flags18", {61'd0, recFlags[18]}, 64'd6);
        chk("rst_redircount", 64'(countOnes(0, 21, 0)), 64'd1);

        // Only two returns: timeout or indefinite wait.
        drive(1, 0, 0, '0);
        sDet[0] = 1; pop(5, 16'h0001); pop(6, 16'h0002);
        runScen(40);
        chk("to_redircount", 64'(countOnes(0, 39, 0)), 64'd0);
`ifdef RTI_TIMEOUT_EN
        chk("to_err19", {63'd0, recErr[19]}, 64'd0);
        chk("to_err20", {62'd0, recErr[20], recBusy[20]}, 64'd2);
        chk("to_errcount", 64'(countOnes(0, 39, 2)), 64'd1);
`else
        chk("to_busy39", {63'd0, recBusy[39]}, 64'd1);
        chk("to_errcount", 64'(countOnes(0, 39, 2)), 64'd0);
`endif

        // Back-to-back sequences.
        drive(1, 0, 0, '0);
        sDet[0] = 1; pop(5, 16'h0001); pop(6, 16'h0000); pop(7, 16'h0123);
        sDet[9] = 1; pop(14, 16'h0004); pop(15, 16'h0001); pop(16, 16'h0040);
        runScen(20);
        chk("b2b_bubble10", {46'd0, recBusy[10], recIv[10], recInstr[10]}, {46'd0, 2'b11, 16'h07F8});
        chk("b2b_redir17", {63'd0, recRedir[17]}, 64'd1);
        chk("b2b_pc17", {32'd0, recPc[17]}, 64'h0001_0040);
        chk("b2b_flags17", {61'd0, recFlags[17]}, 64'd4);

        // Randomized traffic checked by the model every cycle.
        drive(1, 0, 0, '0);
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(199) == 0, $urandom_range(5) == 0,
                  $urandom_range(2) == 0, 16'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
